// File: rtl/ecg_qrs_peak_detect_pkg.sv
`default_nettype none
//==============================================================================
// Module      : ecg_qrs_peak_detect_pkg
// Description : Shared constants, FSM state encoding and saturating |x| helper
//               for the QRS peak detector.
// Revision    : 1.0 - initial release
//==============================================================================
package ecg_qrs_peak_detect_pkg;

    localparam int c_DW_DEF   = 16;
    localparam int c_POSW_DEF = 16;

    typedef logic [1:0] state_t;

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_SEARCH  = 2'd1;
    localparam logic [1:0] c_ST_TRACK   = 2'd2;
    localparam logic [1:0] c_ST_REFRACT = 2'd3;

    // Most negative input has no positive twin; clamp it to the largest positive value.
    function automatic logic [c_DW_DEF-1:0] abs_sat(input logic [c_DW_DEF-1:0] x);
        logic [c_DW_DEF-1:0] neg;
        neg = ~x + 1'b1;
        if (!x[c_DW_DEF-1]) begin
            return x;
        end
        if (neg[c_DW_DEF-1]) begin
            return {1'b0, {(c_DW_DEF-1){1'b1}}};
        end
        return neg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ecg_qrs_peak_detect_if.sv
`default_nettype none
//==============================================================================
// Module      : ecg_qrs_peak_detect_if
// Description : Threshold/sample inputs and peak report outputs of the QRS
//               peak detector.
// Revision    : 1.0 - initial release
//==============================================================================
interface ecg_qrs_peak_detect_if #(
    parameter int DW   = 16,
    parameter int POSW = 16
);
    logic            thr_load;
    logic [DW-1:0]   thr1;
    logic [DW-1:0]   thr2;
    logic [DW-1:0]   data_in;
    logic            data_valid;
    logic            peak_valid;
    logic [POSW-1:0] peak_pos;
    logic [DW-1:0]   peak_amp;
    logic            peak_weak;
    logic            busy;

    modport master (
        output thr_load, thr1, thr2, data_in, data_valid,
        input  peak_valid, peak_pos, peak_amp, peak_weak, busy
    );

    modport slave (
        input  thr_load, thr1, thr2, data_in, data_valid,
        output peak_valid, peak_pos, peak_amp, peak_weak, busy
    );
endinterface
`default_nettype wire

// File: rtl/ecg_qrs_peak_detect_abs_sat.sv
`default_nettype none
//==============================================================================
// Module      : ecg_qrs_peak_detect_abs_sat
// Description : Combinational two's-complement absolute value with saturation.
// Revision    : 1.0 - initial release
//==============================================================================
module ecg_qrs_peak_detect_abs_sat
    import ecg_qrs_peak_detect_pkg::*;
#(
    parameter int DW = c_DW_DEF
) (
    input  logic [DW-1:0] i_x,
    output logic [DW-1:0] o_abs
);

    generate
        if (DW == c_DW_DEF) begin : g_pkg
            assign o_abs = abs_sat(i_x);
        end else begin : g_generic
            logic [DW-1:0] w_neg;
            assign w_neg = ~i_x + 1'b1;
            always_comb begin
                o_abs = i_x;
                if (i_x[DW-1]) begin
                    o_abs = w_neg[DW-1] ? {1'b0, {(DW-1){1'b1}}} : w_neg;
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/ecg_qrs_peak_detect.sv
`default_nettype none
//==============================================================================
// Module      : ecg_qrs_peak_detect
// Description : Locates QRS peaks in the level-3 DWT stream using thr1/thr2
//               and reports index, amplitude and weak/strong flag per complex.
// Revision    : 1.0 - initial release
//==============================================================================
module ecg_qrs_peak_detect
    import ecg_qrs_peak_detect_pkg::*;
#(
    parameter int DW      = c_DW_DEF,
    parameter int POSW    = c_POSW_DEF,
    parameter int REFRACT = 50,
    parameter int MAXW    = 32
) (
    input  logic                 clk,
    input  logic                 nReset,
    ecg_qrs_peak_detect_if.slave bus
);

    localparam int c_RW = $clog2(REFRACT + 2);
    localparam int c_LW = $clog2(MAXW + 1);

    state_t          r_state;
    logic [POSW-1:0] r_idx;
    logic [DW-1:0]   r_thr1;
    logic [DW-1:0]   r_thr2;
    logic [DW-1:0]   r_thr1_p;
    logic [DW-1:0]   r_thr2_p;
    logic [DW-1:0]   r_max_amp;
    logic [POSW-1:0] r_max_pos;
    logic [c_LW-1:0] r_len;
    logic [c_RW-1:0] r_refr;
    logic            r_peak_valid;
    logic [POSW-1:0] r_peak_pos;
    logic [DW-1:0]   r_peak_amp;
    logic            r_peak_weak;

    state_t          w_state_n;
    logic [DW-1:0]   w_abs;
    logic            w_above;
    logic            w_new_max;
    logic            w_len_last;
    logic            w_close;
    logic            w_enter_search;
    logic [DW-1:0]   w_fin_amp;
    logic [POSW-1:0] w_fin_pos;

    ecg_qrs_peak_detect_abs_sat #(
        .DW (DW)
    ) u_abs (
        .i_x   (bus.data_in),
        .o_abs (w_abs)
    );

    assign w_above    = (w_abs > r_thr2);
    assign w_new_max  = (w_abs > r_max_amp);
    assign w_len_last = (r_len == c_LW'(MAXW - 1));

    // Only an above-threshold closing sample (length limit) competes for the peak.
    assign w_fin_amp = (w_above && w_new_max) ? w_abs : r_max_amp;
    assign w_fin_pos = (w_above && w_new_max) ? r_idx : r_max_pos;

    always_comb begin
        w_state_n      = r_state;
        w_close        = 1'b0;
        w_enter_search = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (r_thr2 != '0) begin
                    w_state_n = c_ST_SEARCH;
                end
            end
            c_ST_SEARCH: begin
                if (r_thr2 == '0) begin
                    w_state_n = c_ST_IDLE;
                end else if (bus.data_valid && w_above) begin
                    w_state_n = c_ST_TRACK;
                end
            end
            c_ST_TRACK: begin
                if (bus.data_valid && (!w_above || w_len_last)) begin
                    w_close = 1'b1;
                    if (REFRACT == 0) begin
                        w_state_n      = c_ST_SEARCH;
                        w_enter_search = 1'b1;
                    end else begin
                        w_state_n = c_ST_REFRACT;
                    end
                end
            end
            c_ST_REFRACT: begin
                if (bus.data_valid && (r_refr == c_RW'(1))) begin
                    w_state_n      = c_ST_SEARCH;
                    w_enter_search = 1'b1;
                end
            end
            default: begin
                w_state_n = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nReset) begin
            r_state <= c_ST_IDLE;
            r_idx   <= '0;
            r_refr  <= '0;
        end else begin
            r_state <= w_state_n;
            if (bus.data_valid) begin
                r_idx <= r_idx + 1'b1;
            end
            if (w_close) begin
                r_refr <= c_RW'(REFRACT);
            end else if ((r_state == c_ST_REFRACT) && bus.data_valid) begin
                r_refr <= r_refr - 1'b1;
            end
        end
    end

    // Loads while idle/searching apply at once; otherwise they wait in the
    // pending copy until the FSM is back in SEARCH.
    always_ff @(posedge clk) begin
        if (!nReset) begin
            r_thr1   <= '0;
            r_thr2   <= '0;
            r_thr1_p <= '0;
            r_thr2_p <= '0;
        end else begin
            if (bus.thr_load) begin
                r_thr1_p <= bus.thr1;
                r_thr2_p <= bus.thr2;
            end
            if (bus.thr_load && ((r_state == c_ST_IDLE) || (r_state == c_ST_SEARCH))) begin
                r_thr1 <= bus.thr1;
                r_thr2 <= bus.thr2;
            end else if (w_enter_search) begin
                r_thr1 <= bus.thr_load ? bus.thr1 : r_thr1_p;
                r_thr2 <= bus.thr_load ? bus.thr2 : r_thr2_p;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nReset) begin
            r_max_amp <= '0;
            r_max_pos <= '0;
            r_len     <= '0;
        end else if ((r_state == c_ST_SEARCH) && (w_state_n == c_ST_TRACK)) begin
            r_max_amp <= w_abs;
            r_max_pos <= r_idx;
            r_len     <= c_LW'(1);
        end else if ((r_state == c_ST_TRACK) && bus.data_valid && w_above) begin
            if (w_new_max) begin
                r_max_amp <= w_abs;
                r_max_pos <= r_idx;
            end
            r_len <= r_len + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!nReset) begin
            r_peak_valid <= 1'b0;
            r_peak_pos   <= '0;
            r_peak_amp   <= '0;
            r_peak_weak  <= 1'b0;
        end else begin
            r_peak_valid <= w_close;
            if (w_close) begin
                r_peak_pos  <= w_fin_pos;
                r_peak_amp  <= w_fin_amp;
                r_peak_weak <= (w_fin_amp <= r_thr1);
            end
        end
    end

    assign bus.peak_valid = r_peak_valid;
    assign bus.peak_pos   = r_peak_pos;
    assign bus.peak_amp   = r_peak_amp;
    assign bus.peak_weak  = r_peak_weak;
    assign bus.busy       = (r_state == c_ST_TRACK) || (r_state == c_ST_REFRACT);

endmodule
`default_nettype wire

// File: tb/tb_ecg_qrs_peak_detect.sv
`default_nettype none
//==============================================================================
// Module      : tb_ecg_qrs_peak_detect
// Description : Self-checking bench: directed vector table, corner sequences
//               and random stimulus against a sample-level reference model.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_ecg_qrs_peak_detect;

    localparam int DW      = 16;
    localparam int POSW    = 16;
    localparam int REFRACT = 50;
    localparam int MAXW    = 32;

    logic clk = 1'b0;
    logic nReset;
    always #5 clk = ~clk;

    ecg_qrs_peak_detect_if #(.DW(DW), .POSW(POSW)) bus ();

    ecg_qrs_peak_detect #(
        .DW      (DW),
        .POSW    (POSW),
        .REFRACT (REFRACT),
        .MAXW    (MAXW)
    ) dut (
        .clk    (clk),
        .nReset (nReset),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference model: thresholds, candidate and blanking tracked per sample.
    int m_thr1, m_thr2, p_thr1, p_thr2;
    bit m_armed, m_cand;
    int m_blank, m_max, m_pos, m_len, m_idx;
    bit e_valid, e_weak;
    int e_pos, e_amp;

    function automatic int abs_ref(input int x);
        int a;
        a = (x < 0) ? -x : x;
        return (a > 32767) ? 32767 : a;
    endfunction

    task automatic model_step(input bit rn, input bit v, input int x, input bit ld,
                              input int t1, input int t2);
        int a;
        bit was_open, refill, close;
        if (!rn) begin
            m_thr1 = 0; m_thr2 = 0; p_thr1 = 0; p_thr2 = 0;
            m_armed = 0; m_cand = 0; m_blank = 0;
            m_max = 0; m_pos = 0; m_len = 0; m_idx = 0;
            e_valid = 0; e_weak = 0; e_pos = 0; e_amp = 0;
            return;
        end
        a        = abs_ref(x);
        was_open = !m_cand && (m_blank == 0);
        refill   = 0;
        e_valid  = 0;
        if (m_cand) begin
            if (v) begin
                close = (a <= m_thr2);
                if (!close) begin
                    if (a > m_max) begin
                        m_max = a;
                        m_pos = m_idx;
                    end
                    m_len++;
                    close = (m_len == MAXW);
                end
                if (close) begin
                    e_valid = 1; e_pos = m_pos; e_amp = m_max;
                    e_weak  = (m_max <= m_thr1);
                    m_cand  = 0;
                    if (REFRACT == 0) begin m_armed = 1; refill = 1; end
                    else m_blank = REFRACT;
                end
            end
        end else if (m_blank > 0) begin
            if (v) begin
                m_blank--;
                if (m_blank == 0) begin m_armed = 1; refill = 1; end
            end
        end else if (m_armed) begin
            if (m_thr2 == 0) m_armed = 0;
            else if (v && a > m_thr2) begin
                m_armed = 0; m_cand = 1; m_max = a; m_pos = m_idx; m_len = 1;
            end
        end else if (m_thr2 != 0) begin
            m_armed = 1;
        end
        if (ld) begin
            p_thr1 = t1; p_thr2 = t2;
            if (was_open) begin m_thr1 = t1; m_thr2 = t2; end
        end
        if (refill) begin m_thr1 = p_thr1; m_thr2 = p_thr2; end
        if (v) m_idx = (m_idx + 1) % 65536;
    endtask

    // One clock: drive on the falling edge, observe 1 ns after the rising edge.
    task automatic cyc(input bit rn, input bit v, input int x, input bit ld,
                       input int t1, input int t2);
        @(negedge clk);
        nReset         = rn;
        bus.data_valid = v;
        bus.data_in    = 16'(x);
        bus.thr_load   = ld;
        bus.thr1       = 16'(t1);
        bus.thr2       = 16'(t2);
        model_step(rn, v, x, ld, t1, t2);
        @(posedge clk);
        #1;
        check("model_valid", bus.peak_valid, e_valid);
        check("model_busy", bus.busy, (m_cand || m_blank > 0) ? 1 : 0);
        check("model_pos", bus.peak_pos, e_pos);
        check("model_amp", bus.peak_amp, e_amp);
        check("model_weak", bus.peak_weak, e_weak);
    endtask

    task automatic smp(input int x);
        cyc(1, 1, x, 0, 0, 0);
    endtask

    task automatic idle();
        cyc(1, 0, 0, 0, 0, 0);
    endtask

    task automatic restart(input int t1, input int t2);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, t1, t2);
        idle();
    endtask

    typedef struct {
        bit rn; bit v; int x; bit ld; int t1; int t2;
        bit ev; int epos; int eamp; bit eweak; bit ebusy;
    } vec_t;

    function automatic vec_t mk(input bit rn, input bit v, input int x, input bit ld,
                                input int t1, input int t2, input bit ev, input int epos,
                                input int eamp, input bit eweak, input bit ebusy);
        vec_t r;
        r.rn = rn; r.v = v; r.x = x; r.ld = ld; r.t1 = t1; r.t2 = t2;
        r.ev = ev; r.epos = epos; r.eamp = eamp; r.eweak = eweak; r.ebusy = ebusy;
        return r;
    endfunction

    vec_t tbl[18];

    initial begin
        int pulses, fire_at, r, mode, x;
        nReset = 0;
        bus.thr_load = 0; bus.thr1 = 0; bus.thr2 = 0;
        bus.data_in = 0; bus.data_valid = 0;

        tbl[0]  = mk(0, 0, 0,    0, 0,   0,   0, 0, 0,   0, 0);
        tbl[1]  = mk(1, 0, 0,    1, 400, 200, 0, 0, 0,   0, 0);
        tbl[2]  = mk(1, 0, 0,    0, 0,   0,   0, 0, 0,   0, 0);
        tbl[3]  = mk(1, 1, 0,    0, 0,   0,   0, 0, 0,   0, 0);
        tbl[4]  = mk(1, 1, 150,  0, 0,   0,   0, 0, 0,   0, 0);
        tbl[5]  = mk(1, 1, 300,  0, 0,   0,   0, 0, 0,   0, 1);
        tbl[6]  = mk(1, 1, 700,  0, 0,   0,   0, 0, 0,   0, 1);
        tbl[7]  = mk(1, 1, 500,  0, 0,   0,   0, 0, 0,   0, 1);
        tbl[8]  = mk(1, 1, 100,  0, 0,   0,   1, 3, 700, 0, 1);
        tbl[9]  = mk(1, 0, 0,    0, 0,   0,   0, 3, 700, 0, 1);
        tbl[10] = mk(0, 0, 0,    0, 0,   0,   0, 0, 0,   0, 0);
        tbl[11] = mk(1, 0, 0,    1, 400, 200, 0, 0, 0,   0, 0);
        tbl[12] = mk(1, 0, 0,    0, 0,   0,   0, 0, 0,   0, 0);
        tbl[13] = mk(1, 1, -250, 0, 0,   0,   0, 0, 0,   0, 1);
        tbl[14] = mk(1, 1, -350, 0, 0,   0,   0, 0, 0,   0, 1);
        tbl[15] = mk(1, 1, -300, 0, 0,   0,   0, 0, 0,   0, 1);
        tbl[16] = mk(1, 1, 0,    0, 0,   0,   1, 1, 350, 1, 1);
        tbl[17] = mk(1, 0, 0,    0, 0,   0,   0, 1, 350, 1, 1);

        repeat (3) cyc(0, 0, 0, 0, 0, 0);
        check("reset_valid", bus.peak_valid, 0);
        check("reset_busy", bus.busy, 0);

        for (int i = 0; i < 18; i++) begin
            cyc(tbl[i].rn, tbl[i].v, tbl[i].x, tbl[i].ld, tbl[i].t1, tbl[i].t2);
            check($sformatf("tbl%0d_valid", i), bus.peak_valid, tbl[i].ev);
            check($sformatf("tbl%0d_pos", i), bus.peak_pos, tbl[i].epos);
            check($sformatf("tbl%0d_amp", i), bus.peak_amp, tbl[i].eamp);
            check($sformatf("tbl%0d_weak", i), bus.peak_weak, tbl[i].eweak);
            check($sformatf("tbl%0d_busy", i), bus.busy, tbl[i].ebusy);
        end

        // Second peak falls inside the blanking window.
        restart(400, 200);
        pulses = 0;
        for (int i = 0; i <= 20; i++) begin
            smp((i == 0) ? 500 : ((i == 10) ? 900 : 0));
            if (bus.peak_valid) pulses++;
            if (i >= 1) check($sformatf("twopk_busy%0d", i), bus.busy, 1);
        end
        check("twopk_pulses", pulses, 1);
        check("twopk_pos", bus.peak_pos, 0);
        check("twopk_amp", bus.peak_amp, 500);

        // Flat plateau forces a close at the length limit; tie keeps first index.
        restart(400, 200);
        pulses = 0; fire_at = -1;
        for (int i = 0; i < 40; i++) begin
            smp(1000);
            if (bus.peak_valid) begin pulses++; fire_at = i; end
        end
        check("maxw_pulses", pulses, 1);
        check("maxw_fire_at", fire_at, MAXW - 1);
        check("maxw_pos", bus.peak_pos, 0);
        check("maxw_amp", bus.peak_amp, 1000);
        check("maxw_weak", bus.peak_weak, 0);
        check("maxw_busy", bus.busy, 1);

        // Threshold reload mid-candidate only takes effect after blanking.
        restart(400, 200);
        smp(300);
        smp(600);
        cyc(1, 1, 450, 1, 6000, 5000);
        smp(100);
        check("ld_trk_valid", bus.peak_valid, 1);
        check("ld_trk_pos", bus.peak_pos, 1);
        check("ld_trk_amp", bus.peak_amp, 600);
        check("ld_trk_weak", bus.peak_weak, 0);
        for (int i = 0; i < REFRACT; i++) begin
            check($sformatf("ld_refr_busy%0d", i), bus.busy, 1);
            smp(0);
        end
        check("ld_refr_end_busy", bus.busy, 0);
        smp(3000);
        check("ld_new_thr2_busy", bus.busy, 0);
        smp(6000);
        check("ld_new_trk_busy", bus.busy, 1);
        smp(0);
        check("ld_new_valid", bus.peak_valid, 1);
        check("ld_new_pos", bus.peak_pos, 55);
        check("ld_new_amp", bus.peak_amp, 6000);
        check("ld_new_weak", bus.peak_weak, 1);

        // Reset mid-candidate drops it and leaves the detector idle.
        restart(400, 200);
        smp(500);
        check("rst_trk_busy", bus.busy, 1);
        cyc(0, 1, 0, 0, 0, 0);
        check("rst_valid", bus.peak_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_pos", bus.peak_pos, 0);
        check("rst_amp", bus.peak_amp, 0);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            smp((i % 2 == 0) ? 900 : 0);
            if (bus.peak_valid || bus.busy) pulses++;
        end
        check("rst_idle_activity", pulses, 0);
        cyc(1, 0, 0, 1, 400, 200);
        idle();
        smp(900);
        smp(0);
        check("rst_reload_valid", bus.peak_valid, 1);
        check("rst_reload_pos", bus.peak_pos, 4);
        check("rst_reload_amp", bus.peak_amp, 900);

        // Random traffic against the model.
        restart(400, 200);
        for (int n = 0; n < 4000; n++) begin
            r    = $urandom_range(0, 999);
            mode = $urandom_range(0, 9);
            if (mode == 0)      x = ($urandom_range(0, 1) != 0) ? -32768 : 32767;
            else if (mode < 5)  x = $urandom_range(0, 400) - 200;
            else                x = $urandom_range(0, 8000) - 4000;
            cyc((r != 0) ? 1'b1 : 1'b0,
                ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                x,
                ($urandom_range(0, 149) == 0) ? 1'b1 : 1'b0,
                $urandom_range(0, 4000),
                ($urandom_range(0, 19) == 0) ? 0 : $urandom_range(50, 3000));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/ecg_qrs_peak_detect.md
# ecg_qrs_peak_detect

Consumes the per-window thresholds thr1/thr2 produced by the ECG max/min threshold stage and applies them to the level-3 DWT coefficient stream to locate QRS (R-wave) peaks. Sits downstream of the threshold generator in the feature-extraction chain. Emits one registered peak report per detected QRS complex: sample index, amplitude and a weak/strong flag. A refractory blanking window follows each report.

## Interface
- DW, 16, coefficient and threshold width
- POSW, 16, sample-index width
- REFRACT, 50, blanking length in accepted samples after a report
- MAXW, 32, maximum candidate length in samples before forced close
- clk  in  1  clock; all logic on rising edge
- nReset  in  1  reset, synchronous, active-low
- thr_load  in  1  strobe: capture thr1/thr2
- thr1  in  DW  strong threshold, unsigned
- thr2  in  DW  entry (weak) threshold, unsigned
- data_in  in  DW  signed level-3 coefficient
- data_valid  in  1  data_in qualifier, one sample per asserted cycle
- peak_valid  out  1  one-cycle report pulse
- peak_pos  out  POSW  index of peak sample
- peak_amp  out  DW  absolute peak amplitude, unsigned
- peak_weak  out  1  1 = peak_amp <= thr1
- busy  out  1  state is TRACK or REFRACT

## Operation
- Sample counter: increments on every data_valid, in all states including IDLE; wraps 2^POSW-1 -> 0; a sample's index is the counter value at acceptance; first sample after reset is index 0.
- |x|: two's-complement absolute value, saturating (-32768 -> 32767).
- Threshold regs thr1_r/thr2_r reset to 0. thr_load captures into pending regs; pending copied to active when state is IDLE or SEARCH (same cycle as capture), otherwise on the cycle the FSM enters SEARCH.
- States: IDLE, SEARCH, TRACK, REFRACT.
  - IDLE: active thr2_r == 0; no detection. -> SEARCH when active thr2_r != 0.
  - SEARCH: on data_valid with |x| > thr2_r -> TRACK; max_amp = |x|, max_pos = index, len = 1. Active thr2_r becomes 0 -> IDLE.
  - TRACK: on data_valid, |x| > max_amp updates max (strict: first occurrence wins ties); len++. Close when |x| <= thr2_r or len reaches MAXW: report, -> REFRACT, refr_cnt = REFRACT. Closing sample is not a peak candidate unless the MAXW close occurs while above threshold (then it is compared first).
  - REFRACT: data ignored; refr_cnt-- per data_valid; at 0 -> SEARCH (apply pending thresholds). REFRACT = 0 means direct return to SEARCH.
- Report: peak_amp = max_amp, peak_pos = max_pos, peak_weak = (max_amp <= thr1_r), thresholds as active during TRACK.

## Timing
- Reset values: peak_valid 0, peak_pos 0, peak_amp 0, peak_weak 0, busy 0, state IDLE, counters 0.
- peak_valid asserts for exactly one clk, the cycle after the closing data_valid sample; outputs held until the next report.
- data_valid and thr_load in the same SEARCH cycle: sample compared against old thresholds; new values active next cycle.
- Gaps in data_valid stall all sample-based counters; no timeouts in clk cycles.
- nReset low mid-TRACK/REFRACT: candidate discarded, no report, counters and thresholds cleared.

## Structure
- Shared package ecg_pkg: state enum (IDLE/SEARCH/TRACK/REFRACT), DW/POSW defaults, saturating abs function.
- One sub-module natural: ecg_abs_sat (combinational |x| with saturation), reused by the level-3 slope logic.

## Test plan
- Load thr1=400, thr2=200; feed 0,150,300,700,500,100 at indices 0-5 -> one pulse, peak_pos=3, peak_amp=700, peak_weak=0, one clk after index 5.
- Same thresholds, feed -250,-350,-300,0 -> peak_amp=350, peak_pos=1, peak_weak=1.
- Two peaks 10 samples apart with REFRACT=50 -> only first reported; busy stays 1 through samples of second.
- Constant 1000 for 40 samples, MAXW=32 -> forced report at sample 31, peak_pos=0 (tie rule), then REFRACT.
- thr_load (thr2=5000) during TRACK -> current peak reported with old thresholds; new threshold active only after REFRACT ends.
- nReset low for one clk mid-TRACK -> no peak_valid, all outputs 0, IDLE until thresholds reloaded.
